// File: rtl/serial_subtractor8.sv
// -----------------------------------------------------------------------------
// serial_subtractor8
// Bit-serial unsigned subtractor. An accepted request latches the operands,
// then one difference bit is produced per clock, LSB first, through a single
// full-subtractor cell. After WIDTH shift cycles the assembled difference and
// the final borrow are published on d/bout, and done pulses for one cycle.
//
// Ports
//   clk    in   1      single clock, rising edge
//   rst_n  in   1      synchronous active-low reset
//   start  in   1      begin a subtraction (only honoured while idle)
//   a      in   WIDTH  minuend, unsigned, captured on the accepting edge
//   b      in   WIDTH  subtrahend, unsigned, captured on the accepting edge
//   d      out  WIDTH  registered difference, (a - b) mod 2^WIDTH
//   bout   out  1      registered borrow out, 1 when a < b
//   busy   out  1      operation in progress (SHIFT or DONE)
//   done   out  1      one-cycle pulse: d/bout just took a new result
// -----------------------------------------------------------------------------
module serial_subtractor8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_diff;
  logic [WIDTH-1:0] r_d;
  logic             r_borrow;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_cnt;

  logic             w_last;
  logic             w_diff_bit;
  logic             w_borrow_next;

  // Full-subtractor difference bit.
  function automatic logic sub_diff_f(input logic x, input logic y, input logic r);
    return x ^ y ^ r;
  endfunction

  // Full-subtractor borrow: borrow when y exceeds x, or when x==y and a
  // borrow is already pending from the lower bit.
  function automatic logic sub_borrow_f(input logic x, input logic y, input logic r);
    return (~x & y) | (~(x ^ y) & r);
  endfunction

  // Serial cell and final-bit detection.
  always_comb begin
    w_diff_bit    = sub_diff_f(r_a_sh[0], r_b_sh[0], r_borrow);
    w_borrow_next = sub_borrow_f(r_a_sh[0], r_b_sh[0], r_borrow);
    w_last        = (r_cnt == CW'(WIDTH - 1));
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_SHIFT;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_SHIFT;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register; reset wins over any pending start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand shifters, borrow flop, bit counter and published result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_d      <= '0;
      r_bout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        S_SHIFT: begin
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_diff   <= {w_diff_bit, r_diff[WIDTH-1:1]};
          r_borrow <= w_borrow_next;
          r_cnt    <= r_cnt + CW'(1);
          // The last bit is still in flight, so publish it directly
          // together with the bits already collected.
          if (w_last) begin
            r_d    <= {w_diff_bit, r_diff[WIDTH-1:1]};
            r_bout <= w_borrow_next;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Status flags registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_next != S_IDLE);
      r_done <= (w_state_next == S_DONE);
    end
  end

  assign d    = r_d;
  assign bout = r_bout;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_serial_subtractor8.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor8
// Scoreboard bench: a cycle model decides when a request is accepted, pushes
// the expected {bout, d} for it, and pops it on the edge the result should
// appear. Every output is compared on each falling edge against the model.
// -----------------------------------------------------------------------------
module tb_serial_subtractor8;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  logic [WIDTH:0]   sb_q[$];
  int               m_cnt  = 0;
  logic [WIDTH-1:0] m_d    = '0;
  logic             m_bout = 1'b0;

  serial_subtractor8 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .d     (d),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Cycle model: accept in idle, busy for WIDTH+1 cycles, publish on DONE entry.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_d    <= '0;
      m_bout <= 1'b0;
      sb_q.delete();
    end else if (m_cnt == 0) begin
      if (start) begin
        sb_q.push_back({(a < b), WIDTH'(a - b)});
        m_cnt <= WIDTH + 1;
      end
    end else begin
      if (m_cnt == 2 && sb_q.size() > 0) begin
        {m_bout, m_d} <= sb_q.pop_front();
      end
      m_cnt <= m_cnt - 1;
    end
  end

  // Output monitor.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("busy", {31'd0, busy}, {31'd0, (m_cnt != 0)});
      chk("done", {31'd0, done}, {31'd0, (m_cnt == 1)});
      chk("d",    {24'd0, d},    {24'd0, m_d});
      chk("bout", {31'd0, bout}, {31'd0, m_bout});
    end
  end

  // Wait for the model to return to idle while poking start/a/b randomly.
  task automatic wait_idle();
    int t;
    t = 0;
    while (m_cnt != 0 && t < 30) begin
      @(negedge clk);
      t++;
      if (m_cnt != 0) begin
        start = 1'($urandom_range(0, 1));
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (t >= 30) chk("timeout", 32'd1, 32'd0);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib);
    @(negedge clk);
    a     = ia;
    b     = ib;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = ~ia;
    b     = ~ib;
    wait_idle();
  endtask

  logic [WIDTH-1:0] dir_a [6];
  logic [WIDTH-1:0] dir_b [6];

  initial begin
    dir_a = '{8'h5A, 8'h00, 8'h10, 8'hFF, 8'hFF, 8'h00};
    dir_b = '{8'h23, 8'h01, 8'h80, 8'hFF, 8'h00, 8'hFF};
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    start = 1'b1;          // must be ignored while reset is held
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_op(dir_a[i], dir_b[i]);

    // reset in the middle of a shift sequence
    @(negedge clk);
    a     = 8'h80;
    b     = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h03, 8'h05);

    // start held high, operands changing every cycle
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      start = 1'b1;
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    for (int i = 0; i < 200; i++) run_op(WIDTH'($urandom), WIDTH'($urandom));
    for (int i = 0; i < 20; i++) begin
      logic [WIDTH-1:0] v;
      v = WIDTH'($urandom);
      run_op(v, v);
      run_op(v, v + 8'd1);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
